pipe_ctrl_fsm: RTL and testbench
================================

# pipe_ctrl_fsm

Parametrised pipeline control unit for the RISC-V core: it merges per-stage stall requests into a prefix stall vector. It sequences multi-cycle flushes for exceptions, `mret` and external interrupts, and raises a watchdog flag on runaway stalls. It sits beside the IF/ID/EX/MEM/WB pipeline registers, which consume `stall`, `flush` and `new_pc`, and replaces the single-cycle combinational controller.

## Interface
- STAGES, 6, number of pipeline-register stall bits; bit 0 = PC/IF.
- WIDTH, 32, PC/CSR width.
- FLUSH_CYCLES, 1, cycles `flush` stays high per redirect (>=1).
- WDT_MAX, 255, consecutive stalled cycles before `stall_timeout` pulses (>=1).
- MRET_CODE, 32'h0000000a, `excepttype_i` value meaning `mret`.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stallreq_i  in  STAGES  bit k = stage k requests stall.
- excepttype_i  in  32  nonzero = trap/mret committing this cycle.
- csr_mepc_i  in  WIDTH  return target for `mret`.
- csr_mtvec_i  in  WIDTH  trap vector.
- irq_i  in  1  level external interrupt.
- irq_en_i  in  1  mstatus.MIE.
- stall  out  STAGES  stall vector to pipeline registers.
- flush  out  1  flush all pipeline registers.
- new_pc  out  WIDTH  redirect target, valid while `flush`=1.
- irq_taken_o  out  1  1-cycle pulse: interrupt accepted (CSR unit saves mepc/mcause).
- stall_timeout  out  1  1-cycle watchdog pulse.
- busy  out  1  FSM not in RUN.

## Operation
- FSM states: RUN, FLUSH.
- RUN, stall generation (combinational): h = highest set bit of `stallreq_i`; `stall[h:0]`=1, the rest 0; all 0 if no request. Example with STAGES=6: request bit 4 -> 6'b011111.
- RUN, event priority (highest first):
  - `excepttype_i`!=0 -> redirect. Target = `csr_mepc_i` if equal to MRET_CODE, else `csr_mtvec_i`.
  - `irq_i & irq_en_i` with `stallreq_i`==0 -> redirect to `csr_mtvec_i` and pulse `irq_taken_o`.
  - An interrupt is never taken while any stall is requested; it stays pending because the input is level.
- Redirect: capture target into the `new_pc` register; load the flush counter with FLUSH_CYCLES-1; enter FLUSH.
- FLUSH:
  - `flush`=1 and `stall`=0 regardless of `stallreq_i`.
  - `excepttype_i` and `irq_i` are ignored, since they come from squashed instructions.
  - Counter decrements each cycle; at 0 return to RUN.
- Watchdog:
  - 16-bit counter increments each cycle `stall`!=0 and clears when `stall`==0.
  - On reaching WDT_MAX: pulse `stall_timeout`, clear the counter and keep counting.
  - Counter is cleared in FLUSH.
- `new_pc` holds its last target outside FLUSH. It reads 0 after reset until the first redirect.

## Timing
- Reset values: state RUN, `stall`=0, `flush`=0, `new_pc`=0, `irq_taken_o`=0, `stall_timeout`=0, `busy`=0, counters 0.
- `stall` is combinational from `stallreq_i` and state, with zero latency.
- Redirect latency:
  - Event sampled at edge t.
  - `flush`=1 and `new_pc`=target from cycle t+1 through t+FLUSH_CYCLES.
  - RUN resumes at t+FLUSH_CYCLES+1.
- `irq_taken_o` is registered and high in cycle t+1 only.
- `busy` equals `flush`.
- Exception and interrupt in the same cycle: the exception wins and `irq_taken_o` stays 0.
- Exception and stall request in the same cycle: redirect wins. `stall` is still driven from requests in that cycle and forced 0 from t+1.
- Reset asserted mid-FLUSH: next cycle is RUN with all outputs at reset values.
- A back-to-back event on the first RUN cycle after FLUSH is accepted normally.

## Test plan
- Reset, then `stallreq_i`=6'b010000 -> `stall`=6'b011111 same cycle. Then 6'b000110 -> 6'b000111. Then 0 -> 0.
- FLUSH_CYCLES=3, `excepttype_i`=2, `csr_mtvec_i`=0x100 for one cycle -> `flush`=1 and `new_pc`=0x100 for exactly 3 cycles, `busy` matches, then RUN.
- `excepttype_i`=0x0000000a with `csr_mepc_i`=0x2040 -> `new_pc`=0x2040. Exceptions injected during FLUSH produce no extra flush cycles.
- `irq_i`=1, `irq_en_i`=1, `stallreq_i`=6'b000100 for 5 cycles then 0 -> no redirect during the stall; `irq_taken_o` pulses on the cycle after the stall clears; `new_pc`=mtvec. With `irq_en_i`=0 there is never a redirect.
- Same-cycle exception (mtvec 0x100) and irq -> single redirect to 0x100 with `irq_taken_o`=0. Assert `rst` on the 2nd FLUSH cycle -> all outputs 0 the next cycle.
- WDT_MAX=10, `stallreq_i` held at 6'b000001 for 25 cycles -> `stall_timeout` pulses at the 10th and 20th stalled cycles only.

Source files
------------

// File: rtl/pipe_ctrl_fsm.sv
// Pipeline control unit: prefix stall vector, multi-cycle flush sequencing for
// traps/mret/interrupts, and a watchdog that flags runaway stalls.
module pipe_ctrl_fsm #(
    parameter int          STAGES       = 6,
    parameter int          WIDTH        = 32,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          WDT_MAX      = 255,
    parameter logic [31:0] MRET_CODE    = 32'h0000000a
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq_i,
    input  logic [31:0]       excepttype_i,
    input  logic [WIDTH-1:0]  csr_mepc_i,
    input  logic [WIDTH-1:0]  csr_mtvec_i,
    input  logic              irq_i,
    input  logic              irq_en_i,
    output logic [STAGES-1:0] stall,
    output logic              flush,
    output logic [WIDTH-1:0]  new_pc,
    output logic              irq_taken_o,
    output logic              stall_timeout,
    output logic              busy
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    localparam int            CW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT  = CW'(FLUSH_CYCLES - 1);
    localparam logic [15:0]   WDT_LAST  = 16'(WDT_MAX - 1);

    logic [0:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  newPc_q, newPc_d;
    logic              irqTaken_q, irqTaken_d;
    logic [15:0]       wdt_q, wdt_d;
    logic [STAGES-1:0] stallPrefix;
    logic              wdtHit;

    // A stage stalls whenever it or any later stage requests a stall.
    always_comb begin
        stallPrefix = '0;
        for (int i = 0; i < STAGES; i++) begin
            stallPrefix[i] = |(stallreq_i >> i);
        end
    end

    assign stall         = (state_q == RUN) ? stallPrefix : '0;
    assign flush         = (state_q == FLUSH);
    assign busy          = flush;
    assign new_pc        = newPc_q;
    assign irq_taken_o   = irqTaken_q;
    assign wdtHit        = (|stall) && (wdt_q == WDT_LAST);
    assign stall_timeout = wdtHit;

    always_comb begin
        if (!(|stall) || wdtHit) begin
            wdt_d = '0;
        end else begin
            wdt_d = wdt_q + 16'd1;
        end
    end

    // Interrupts wait for an unstalled cycle so no half-retired instruction is lost.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        newPc_d    = newPc_q;
        irqTaken_d = 1'b0;
        case (state_q)
            RUN: begin
                if (excepttype_i != '0) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_INIT;
                    newPc_d = (excepttype_i == MRET_CODE) ? csr_mepc_i : csr_mtvec_i;
                end else if (irq_i && irq_en_i && (stallreq_i == '0)) begin
                    state_d    = FLUSH;
                    cnt_d      = CNT_INIT;
                    newPc_d    = csr_mtvec_i;
                    irqTaken_d = 1'b1;
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            newPc_q    <= '0;
            irqTaken_q <= 1'b0;
            wdt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            newPc_q    <= newPc_d;
            irqTaken_q <= irqTaken_d;
            wdt_q      <= wdt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// Self-checking bench for pipe_ctrl_fsm: directed vector table, watchdog run,
// then randomized traffic against a cycle-level behavioural model.
module tb_pipe_ctrl_fsm;

    localparam int          STAGES       = 6;
    localparam int          WIDTH        = 32;
    localparam int          FLUSH_CYCLES = 3;
    localparam int          WDT_MAX      = 10;
    localparam logic [31:0] MRET         = 32'h0000000a;

    logic              clk = 1'b0;
    logic              rst;
    logic [STAGES-1:0] stallreq_i;
    logic [31:0]       excepttype_i;
    logic [WIDTH-1:0]  csr_mepc_i;
    logic [WIDTH-1:0]  csr_mtvec_i;
    logic              irq_i;
    logic              irq_en_i;
    logic [STAGES-1:0] stall;
    logic              flush;
    logic [WIDTH-1:0]  new_pc;
    logic              irq_taken_o;
    logic              stall_timeout;
    logic              busy;

    pipe_ctrl_fsm #(
        .STAGES(STAGES), .WIDTH(WIDTH), .FLUSH_CYCLES(FLUSH_CYCLES),
        .WDT_MAX(WDT_MAX), .MRET_CODE(MRET)
    ) dut (
        .clk(clk), .rst(rst), .stallreq_i(stallreq_i), .excepttype_i(excepttype_i),
        .csr_mepc_i(csr_mepc_i), .csr_mtvec_i(csr_mtvec_i), .irq_i(irq_i),
        .irq_en_i(irq_en_i), .stall(stall), .flush(flush), .new_pc(new_pc),
        .irq_taken_o(irq_taken_o), .stall_timeout(stall_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  req;
        logic [31:0] exc;
        logic [31:0] mepc;
        logic [31:0] mtvec;
        logic        irq;
        logic        en;
        logic        rstIn;
        logic [5:0]  expStall;
        logic        expFlush;
        logic [31:0] expPc;
        logic        expIrq;
        logic        expTo;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    // Behavioural model: remaining flush cycles, last target, consecutive stall run.
    int          flushLeft = 0;
    logic [31:0] mPc       = '0;
    logic        mIrq      = 1'b0;
    int          stallRun  = 0;

    function automatic vec_t mk(logic [5:0] req, logic [31:0] exc, logic [31:0] mepc,
                                logic [31:0] mtvec, logic irq, logic en, logic r,
                                logic [5:0] eStall, logic eFlush, logic [31:0] ePc,
                                logic eIrq, logic eTo);
        vec_t v;
        v.req = req; v.exc = exc; v.mepc = mepc; v.mtvec = mtvec;
        v.irq = irq; v.en = en; v.rstIn = r;
        v.expStall = eStall; v.expFlush = eFlush; v.expPc = ePc;
        v.expIrq = eIrq; v.expTo = eTo;
        return v;
    endfunction

    function automatic logic [5:0] prefixStall(logic [5:0] r);
        int h = -1;
        for (int i = 0; i < STAGES; i++) if (r[i]) h = i;
        if (h < 0) return 6'd0;
        return 6'((1 << (h + 1)) - 1);
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(vec_t v);
        @(negedge clk);
        stallreq_i   = v.req;
        excepttype_i = v.exc;
        csr_mepc_i   = v.mepc;
        csr_mtvec_i  = v.mtvec;
        irq_i        = v.irq;
        irq_en_i     = v.en;
        rst          = v.rstIn;
        #1;
    endtask

    task automatic checkOutput(string tag, logic [5:0] eStall, logic eFlush,
                               logic [31:0] ePc, logic eIrq, logic eTo);
        cmp({tag, ".stall"}, 32'(stall), 32'(eStall));
        cmp({tag, ".flush"}, 32'(flush), 32'(eFlush));
        cmp({tag, ".busy"}, 32'(busy), 32'(eFlush));
        cmp({tag, ".new_pc"}, new_pc, ePc);
        cmp({tag, ".irq_taken"}, 32'(irq_taken_o), 32'(eIrq));
        cmp({tag, ".timeout"}, 32'(stall_timeout), 32'(eTo));
    endtask

    task automatic modelExpect(output logic [5:0] eStall, output logic eFlush,
                               output logic [31:0] ePc, output logic eIrq, output logic eTo);
        eFlush = (flushLeft > 0);
        eStall = eFlush ? 6'd0 : prefixStall(stallreq_i);
        ePc    = mPc;
        eIrq   = mIrq;
        eTo    = (eStall != 0) && (((stallRun + 1) % WDT_MAX) == 0);
    endtask

    task automatic modelAdvance();
        logic [5:0]  s;
        logic        f;
        logic [31:0] p;
        logic        q;
        logic        t;
        modelExpect(s, f, p, q, t);
        if (rst) begin
            flushLeft = 0; mPc = '0; mIrq = 1'b0; stallRun = 0;
        end else begin
            stallRun = (s != 0) ? stallRun + 1 : 0;
            if (flushLeft > 0) begin
                flushLeft--;
                mIrq = 1'b0;
            end else if (excepttype_i != 0) begin
                flushLeft = FLUSH_CYCLES;
                mPc  = (excepttype_i == MRET) ? csr_mepc_i : csr_mtvec_i;
                mIrq = 1'b0;
            end else if (irq_i && irq_en_i && stallreq_i == 0) begin
                flushLeft = FLUSH_CYCLES;
                mPc  = csr_mtvec_i;
                mIrq = 1'b1;
            end else begin
                mIrq = 1'b0;
            end
        end
    endtask

    initial begin
        vec_t        v;
        logic [5:0]  eS;
        logic        eF;
        logic [31:0] eP;
        logic        eI;
        logic        eT;

        rst = 1'b1; stallreq_i = '0; excepttype_i = '0; csr_mepc_i = '0;
        csr_mtvec_i = '0; irq_i = 1'b0; irq_en_i = 1'b0;

        //          req        exc    mepc     mtvec    irq en rst  stall      fl pc       irqT to
        vecs.push_back(mk(6'b010000, 0,     'h2040, 'h100, 0, 0, 0, 6'b011111, 0, 'h0,    0, 0));
        vecs.push_back(mk(6'b000110, 0,     'h2040, 'h100, 0, 0, 0, 6'b000111, 0, 'h0,    0, 0));
        vecs.push_back(mk(6'b000000, 0,     'h2040, 'h100, 0, 0, 0, 6'b000000, 0, 'h0,    0, 0));
        vecs.push_back(mk(6'b000000, 2,     'h2040, 'h100, 0, 0, 0, 6'b000000, 0, 'h0,    0, 0));
        vecs.push_back(mk(6'b000000, 0,     'h2040, 'h100, 0, 0, 0, 6'b000000, 1, 'h100,  0, 0));
        vecs.push_back(mk(6'b111111, 2,     'h2040, 'h200, 0, 0, 0, 6'b000000, 1, 'h100,  0, 0));
        vecs.push_back(mk(6'b000000, 0,     'h2040, 'h200, 1, 1, 0, 6'b000000, 1, 'h100,  0, 0));
        vecs.push_back(mk(6'b000000, MRET,  'h2040, 'h100, 0, 0, 0, 6'b000000, 0, 'h100,  0, 0));
        vecs.push_back(mk(6'b000000, 0,     'h2040, 'h100, 0, 0, 0, 6'b000000, 1, 'h2040, 0, 0));
        vecs.push_back(mk(6'b000000, 0,     'h2040, 'h100, 0, 0, 0, 6'b000000, 1, 'h2040, 0, 0));
        vecs.push_back(mk(6'b000000, 0,     'h2040, 'h100, 0, 0, 0, 6'b000000, 1, 'h2040, 0, 0));
        vecs.push_back(mk(6'b001000, 2,     'h2040, 'h100, 0, 0, 0, 6'b001111, 0, 'h2040, 0, 0));
        vecs.push_back(mk(6'b001000, 0,     'h2040, 'h100, 0, 0, 0, 6'b000000, 1, 'h100,  0, 0));
        vecs.push_back(mk(6'b000000, 0,     'h2040, 'h100, 0, 0, 0, 6'b000000, 1, 'h100,  0, 0));
        vecs.push_back(mk(6'b000000, 0,     'h2040, 'h100, 0, 0, 0, 6'b000000, 1, 'h100,  0, 0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(6'b000100, 0, 'h2040, 'h300, 1, 1, 0, 6'b000111, 0, 'h100,  0, 0));
        vecs.push_back(mk(6'b000000, 0,     'h2040, 'h300, 1, 1, 0, 6'b000000, 0, 'h100,  0, 0));
        vecs.push_back(mk(6'b000000, 0,     'h2040, 'h300, 0, 0, 0, 6'b000000, 1, 'h300,  1, 0));
        vecs.push_back(mk(6'b000000, 0,     'h2040, 'h300, 0, 0, 0, 6'b000000, 1, 'h300,  0, 0));
        vecs.push_back(mk(6'b000000, 0,     'h2040, 'h300, 0, 0, 0, 6'b000000, 1, 'h300,  0, 0));
        vecs.push_back(mk(6'b000000, 0,     'h2040, 'h300, 1, 0, 0, 6'b000000, 0, 'h300,  0, 0));
        vecs.push_back(mk(6'b000000, 0,     'h2040, 'h300, 1, 0, 0, 6'b000000, 0, 'h300,  0, 0));
        vecs.push_back(mk(6'b000000, 2,     'h2040, 'h100, 1, 1, 0, 6'b000000, 0, 'h300,  0, 0));
        vecs.push_back(mk(6'b000000, 0,     'h2040, 'h100, 0, 0, 0, 6'b000000, 1, 'h100,  0, 0));
        vecs.push_back(mk(6'b000000, 0,     'h2040, 'h100, 0, 0, 1, 6'b000000, 1, 'h100,  0, 0));
        vecs.push_back(mk(6'b000000, 0,     'h2040, 'h100, 0, 0, 0, 6'b000000, 0, 'h0,    0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset", 6'd0, 1'b0, 32'h0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("row%0d", i), vecs[i].expStall, vecs[i].expFlush,
                        vecs[i].expPc, vecs[i].expIrq, vecs[i].expTo);
            modelAdvance();
        end

        // Watchdog: 25 consecutive stalled cycles, pulses on the 10th and 20th.
        for (int k = 0; k < 25; k++) begin
            v = mk(6'b000001, 0, 'h2040, 'h100, 0, 0, 0, 6'b000001, 0, 'h0, 0, (k == 9 || k == 19));
            applyStimulus(v);
            checkOutput($sformatf("wdt%0d", k), v.expStall, v.expFlush, v.expPc, v.expIrq, v.expTo);
            modelAdvance();
        end

        for (int n = 0; n < 400; n++) begin
            v.req   = ($urandom_range(1) == 0) ? 6'd0 : 6'($urandom_range(63));
            v.exc   = ($urandom_range(7) != 0) ? 32'd0 :
                      (($urandom_range(1) == 0) ? MRET : 32'($urandom_range(20, 1)));
            v.mepc  = $urandom;
            v.mtvec = $urandom;
            v.irq   = 1'($urandom_range(1));
            v.en    = 1'($urandom_range(1));
            v.rstIn = ($urandom_range(60) == 0);
            applyStimulus(v);
            modelExpect(eS, eF, eP, eI, eT);
            checkOutput($sformatf("rnd%0d", n), eS, eF, eP, eI, eT);
            modelAdvance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
